// File: rtl/lcd_backlight_pwm_pkg.sv
// Shared definitions for the LCD backlight PWM: register map, CTRL bit
// positions, FSM state encoding and the STATUS word packer.
package lcd_backlight_pwm_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PERIOD = 2'd1;
  localparam logic [1:0] ADDR_DUTY   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_FADE_BIT = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } pwm_state_e;

  function automatic logic [31:0] status_word(input logic running,
                                              input logic fading,
                                              input logic [15:0] duty_act);
    return {duty_act, 14'd0, fading, running};
  endfunction

endpackage

// File: rtl/lcd_pwm_core.sv
// PWM engine: period counter, active period/duty shadow registers, optional
// +/-1 duty fade, and the registered backlight output.
module lcd_pwm_core
  import lcd_backlight_pwm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic             fade_en,
  input  logic [CNT_W-1:0] period_reg,
  input  logic [CNT_W-1:0] duty_tgt,
  output logic             pwm_out,
  output logic             running,
  output logic             fading,
  output logic [CNT_W-1:0] duty_act
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  pwm_state_e       state_r, state_next_s;
  logic [CNT_W-1:0] cnt_r, cnt_next_s;
  logic [CNT_W-1:0] period_act_r, period_act_next_s;
  logic [CNT_W-1:0] duty_act_r, duty_act_next_s;
  logic             pwm_r, pwm_next_s;

  function automatic logic [CNT_W-1:0] fade_step(input logic [CNT_W-1:0] cur,
                                                 input logic [CNT_W-1:0] tgt);
    if (cur < tgt) begin
      return cur + CNT_ONE;
    end else if (cur > tgt) begin
      return cur - CNT_ONE;
    end else begin
      return cur;
    end
  endfunction

  // Next-state logic; shadow registers only move on entry or at the terminal count.
  always_comb begin
    state_next_s      = state_r;
    cnt_next_s        = cnt_r;
    period_act_next_s = period_act_r;
    duty_act_next_s   = duty_act_r;
    case (state_r)
      ST_IDLE: begin
        cnt_next_s = CNT_ZERO;
        if (run) begin
          state_next_s      = ST_RUN;
          period_act_next_s = period_reg;
          duty_act_next_s   = fade_en ? CNT_ZERO : duty_tgt;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!run) begin
          state_next_s = ST_IDLE;
          cnt_next_s   = CNT_ZERO;
        end else if (cnt_r == period_act_r) begin
          cnt_next_s        = CNT_ZERO;
          period_act_next_s = period_reg;
          duty_act_next_s   = fade_en ? fade_step(duty_act_r, duty_tgt) : duty_tgt;
        end else begin
          cnt_next_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        cnt_next_s   = CNT_ZERO;
      end
    endcase
    // Output is derived from the post-edge count so it lines up with cnt_r.
    pwm_next_s = (state_next_s == ST_RUN) && (cnt_next_s < duty_act_next_s);
  end

  // State, counter, shadow registers and output flop.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      cnt_r        <= CNT_ZERO;
      period_act_r <= CNT_ZERO;
      duty_act_r   <= CNT_ZERO;
      pwm_r        <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      cnt_r        <= cnt_next_s;
      period_act_r <= period_act_next_s;
      duty_act_r   <= duty_act_next_s;
      pwm_r        <= pwm_next_s;
    end
  end

  assign pwm_out  = pwm_r;
  assign running  = (state_r == ST_RUN);
  assign fading   = running && fade_en && (duty_act_r != duty_tgt);
  assign duty_act = duty_act_r;

endmodule

// File: rtl/lcd_backlight_pwm.sv
// Avalon-MM slave wrapper for the backlight PWM: CTRL/PERIOD/DUTY register
// file, zero-latency read mux and the gated run enable.
module lcd_backlight_pwm
  import lcd_backlight_pwm_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int RST_PERIOD = 999,
  parameter int RST_DUTY   = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        enable_in,
  output logic        pwm_out
);

  logic             ctrl_en_r;
  logic             fade_en_r;
  logic [CNT_W-1:0] period_reg_r;
  logic [CNT_W-1:0] duty_tgt_r;
  logic             write_s;
  logic             run_s;
  logic             running_s;
  logic             fading_s;
  logic [CNT_W-1:0] duty_act_s;
  logic             unused_wr_bits_s;

  assign write_s = chipselect && !write_n;
  assign run_s   = ctrl_en_r && enable_in;
  // Bits above the counter width are discarded on write.
  assign unused_wr_bits_s = ^writedata[31:CNT_W];

  // Register file; STATUS writes are dropped.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ctrl_en_r    <= 1'b0;
      fade_en_r    <= 1'b0;
      period_reg_r <= CNT_W'(RST_PERIOD);
      duty_tgt_r   <= CNT_W'(RST_DUTY);
    end else if (write_s) begin
      case (address)
        ADDR_CTRL: begin
          ctrl_en_r <= writedata[CTRL_EN_BIT];
          fade_en_r <= writedata[CTRL_FADE_BIT];
        end
        ADDR_PERIOD: period_reg_r <= writedata[CNT_W-1:0];
        ADDR_DUTY:   duty_tgt_r   <= writedata[CNT_W-1:0];
        default:     ctrl_en_r    <= ctrl_en_r;
      endcase
    end else begin
      ctrl_en_r <= ctrl_en_r;
    end
  end

  // Combinational read mux, zero-extended.
  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_CTRL:   readdata = {30'd0, fade_en_r, ctrl_en_r};
      ADDR_PERIOD: readdata = 32'(period_reg_r);
      ADDR_DUTY:   readdata = 32'(duty_tgt_r);
      ADDR_STATUS: readdata = status_word(running_s, fading_s, 16'(duty_act_s));
      default:     readdata = 32'd0;
    endcase
  end

  lcd_pwm_core #(
    .CNT_W(CNT_W)
  ) u_core (
    .clk       (clk),
    .reset_n   (reset_n),
    .run       (run_s),
    .fade_en   (fade_en_r),
    .period_reg(period_reg_r),
    .duty_tgt  (duty_tgt_r),
    .pwm_out   (pwm_out),
    .running   (running_s),
    .fading    (fading_s),
    .duty_act  (duty_act_s)
  );

endmodule

// File: tb/tb_lcd_backlight_pwm.sv
// Bench for lcd_backlight_pwm: directed scenarios with fixed expectations plus
// a randomized run checked against a period/position reference model.
module tb_lcd_backlight_pwm;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        enable_in = 1'b0;
  logic        pwm_out;

  int errors = 0;
  int checks = 0;

  // Reference model: register copies plus position within the current period.
  bit m_en, m_fade, m_active;
  int m_period, m_duty, m_pos, m_len, m_high;

  always #5 clk = ~clk;

  lcd_backlight_pwm dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .enable_in (enable_in),
    .pwm_out   (pwm_out)
  );

  always @(posedge clk) begin
    if (!reset_n) begin
      m_en <= 0; m_fade <= 0; m_period <= 999; m_duty <= 0;
      m_active <= 0; m_pos <= 0; m_len <= 1; m_high <= 0;
    end else begin
      if (chipselect && !write_n) begin
        case (address)
          2'd0: begin m_en <= writedata[0]; m_fade <= writedata[1]; end
          2'd1: m_period <= int'(writedata & 32'h0000_FFFF);
          2'd2: m_duty   <= int'(writedata & 32'h0000_FFFF);
          default: ;
        endcase
      end
      if (!(m_en && enable_in)) begin
        m_active <= 0; m_pos <= 0;
      end else if (!m_active || m_pos == m_len - 1) begin
        m_active <= 1; m_pos <= 0; m_len <= m_period + 1;
        if (!m_active)
          m_high <= m_fade ? 0 : m_duty;
        else if (!m_fade)
          m_high <= m_duty;
        else
          m_high <= m_high + (m_duty > m_high ? 1 : 0) - (m_duty < m_high ? 1 : 0);
      end else begin
        m_pos <= m_pos + 1;
      end
    end
  end

  function automatic logic model_pwm();
    return m_active && (m_pos < m_high);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [1:0] a);
    logic fading;
    fading = m_active && m_fade && (m_high != m_duty);
    case (a)
      2'd0:    return {30'd0, m_fade, m_en};
      2'd1:    return 32'(m_period);
      2'd2:    return 32'(m_duty);
      default: return {16'(m_high), 14'd0, fading, m_active};
    endcase
  endfunction

  // Called at a falling edge; the write is captured on the next rising edge.
  task automatic avalon_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic wait_rise(output bit ok);
    logic prev;
    ok = 0;
    prev = pwm_out;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!prev && pwm_out) begin ok = 1; break; end
      prev = pwm_out;
    end
  endtask

  task automatic test_reset();
    int exp_rst[4];
    exp_rst = '{0, 999, 0, 0};
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (pwm_out !== 1'b0) begin errors++; $display("FAIL reset_pwm got=%0b exp=0", pwm_out); end
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      #1;
      checks++;
      if (readdata !== 32'(exp_rst[a])) begin
        errors++; $display("FAIL reset_read addr=%0d got=%0d exp=%0d", a, readdata, exp_rst[a]);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int hi;
    enable_in = 1'b1;
    avalon_write(2'd1, 32'd9);
    avalon_write(2'd2, 32'd3);
    avalon_write(2'd0, 32'd1);
    @(negedge clk);
    checks++;
    if (pwm_out !== 1'b1) begin errors++; $display("FAIL basic_first_high got=%0b exp=1", pwm_out); end
    hi = int'(pwm_out);
    for (int i = 1; i < 30; i++) begin @(negedge clk); hi += int'(pwm_out); end
    checks++;
    if (hi != 9) begin errors++; $display("FAIL basic_high_count got=%0d exp=9", hi); end
    address = 2'd3; #1;
    checks++;
    if (readdata[0] !== 1'b1 || readdata[31:16] !== 16'd3) begin
      errors++; $display("FAIL basic_status got=%08h exp=running,duty 3", readdata);
    end
    @(negedge clk);
  endtask

  task automatic test_midwrite();
    bit ok;
    int hi;
    wait_rise(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL mid_rise_timeout got=none exp=rising edge"); end
    hi = int'(pwm_out);
    chipselect = 1'b1; write_n = 1'b0; address = 2'd2; writedata = 32'd7;
    @(negedge clk);
    hi += int'(pwm_out);
    chipselect = 1'b0; write_n = 1'b1;
    for (int i = 0; i < 8; i++) begin @(negedge clk); hi += int'(pwm_out); end
    checks++;
    if (hi != 3) begin errors++; $display("FAIL mid_current_period got=%0d exp=3", hi); end
    hi = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); hi += int'(pwm_out); end
    checks++;
    if (hi != 7) begin errors++; $display("FAIL mid_next_period got=%0d exp=7", hi); end
  endtask

  task automatic test_limits();
    int hi;
    avalon_write(2'd2, 32'd20);
    repeat (12) @(negedge clk);
    hi = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); hi += int'(pwm_out); end
    checks++;
    if (hi != 20) begin errors++; $display("FAIL limit_duty_over got=%0d exp=20", hi); end
    avalon_write(2'd2, 32'd0);
    repeat (12) @(negedge clk);
    hi = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); hi += int'(pwm_out); end
    checks++;
    if (hi != 0) begin errors++; $display("FAIL limit_duty_zero got=%0d exp=0", hi); end
    avalon_write(2'd1, 32'd0);
    avalon_write(2'd2, 32'd1);
    repeat (12) @(negedge clk);
    hi = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); hi += int'(pwm_out); end
    checks++;
    if (hi != 10) begin errors++; $display("FAIL limit_period_zero got=%0d exp=10", hi); end
  endtask

  task automatic test_fade();
    bit ok;
    int hi;
    int exp_w[5];
    exp_w = '{1, 2, 3, 4, 4};
    avalon_write(2'd1, 32'd9);
    avalon_write(2'd2, 32'd0);
    repeat (25) @(negedge clk);
    avalon_write(2'd0, 32'd3);
    avalon_write(2'd2, 32'd4);
    address = 2'd3; #1;
    checks++;
    if (readdata[1] !== 1'b1) begin errors++; $display("FAIL fade_flag_set got=%0b exp=1", readdata[1]); end
    wait_rise(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL fade_rise_timeout got=none exp=rising edge"); end
    for (int p = 0; p < 5; p++) begin
      hi = 0;
      for (int i = 0; i < 10; i++) begin
        if (p != 0 || i != 0) @(negedge clk);
        hi += int'(pwm_out);
      end
      checks++;
      if (hi != exp_w[p]) begin errors++; $display("FAIL fade_width p=%0d got=%0d exp=%0d", p, hi, exp_w[p]); end
    end
    #1;
    checks++;
    if (readdata[1] !== 1'b0 || readdata[31:16] !== 16'd4) begin
      errors++; $display("FAIL fade_flag_clear got=%08h exp=fading 0,duty 4", readdata);
    end
    @(negedge clk);
  endtask

  task automatic test_disable();
    bit ok;
    int hi;
    avalon_write(2'd0, 32'd1);
    wait_rise(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL dis_rise_timeout got=none exp=rising edge"); end
    enable_in = 1'b0;
    @(negedge clk);
    checks++;
    if (pwm_out !== 1'b0) begin errors++; $display("FAIL dis_drop got=%0b exp=0", pwm_out); end
    address = 2'd3; #1;
    checks++;
    if (readdata[0] !== 1'b0) begin errors++; $display("FAIL dis_running got=%0b exp=0", readdata[0]); end
    repeat (4) @(negedge clk);
    enable_in = 1'b1;
    @(negedge clk);
    checks++;
    if (pwm_out !== 1'b1) begin errors++; $display("FAIL dis_restart_first got=%0b exp=1", pwm_out); end
    hi = int'(pwm_out);
    for (int i = 1; i < 10; i++) begin @(negedge clk); hi += int'(pwm_out); end
    checks++;
    if (hi != 4) begin errors++; $display("FAIL dis_restart_width got=%0d exp=4", hi); end
    wait_rise(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_rise_timeout got=none exp=rising edge"); end
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if (pwm_out !== 1'b0) begin errors++; $display("FAIL rst_mid_pwm got=%0b exp=0", pwm_out); end
    address = 2'd1; #1;
    checks++;
    if (readdata !== 32'd999) begin errors++; $display("FAIL rst_mid_period got=%0d exp=999", readdata); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [1:0]  a;
    logic [31:0] d;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      checks++;
      if (pwm_out !== model_pwm()) begin
        errors++; $display("FAIL rand_pwm n=%0d got=%0b exp=%0b", n, pwm_out, model_pwm());
      end
      checks++;
      if (readdata !== exp_rd(address)) begin
        errors++; $display("FAIL rand_read n=%0d addr=%0d got=%08h exp=%08h", n, address, readdata, exp_rd(address));
      end
      a = 2'($urandom_range(0, 3));
      case (a)
        2'd1:    d = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 12));
        2'd2:    d = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 15));
        default: d = $urandom;
      endcase
      address    = a;
      writedata  = d;
      chipselect = 1'($urandom_range(0, 1));
      write_n    = ($urandom_range(0, 7) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 63) == 0) enable_in = ~enable_in;
    end
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_midwrite();
    test_limits();
    test_fade();
    test_disable();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
